// File: rtl/m31_pkg.sv
// Shared types for the M31 Poseidon2 full-round driver: field word, modulus,
// and the driver FSM state encoding.
package m31_pkg;

  typedef logic [30:0] m31_t;

  localparam logic [30:0] M31_P = 31'h7FFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } m31_frd_state_e;

endpackage

// File: rtl/m31_full_round_driver.sv
// Sequences one state through NUM_ROUNDS passes of the external full-round datapath.
// Optional counters are built when M31_FULL_ROUND_DRIVER_PERF_EN is defined.
module m31_full_round_driver
  import m31_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int NUM_ROUNDS = 4,
  parameter int LAT        = 13,
  parameter int RC_AW      = 6,
  parameter int RC_BASE    = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*31-1:0]    in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*31-1:0]    out_state,
  output logic [RC_AW-1:0]       rc_addr,
  input  logic [WIDTH*31-1:0]    rc_data,
  output logic [WIDTH*31-1:0]    fr_state_o,
  output logic [WIDTH*31-1:0]    fr_const_o,
  input  logic [WIDTH*31-1:0]    fr_state_i,
  output logic                   busy,
  output logic [2:0]             fsm_state
`ifdef M31_FULL_ROUND_DRIVER_PERF_EN
  ,
  output logic [31:0]            perf_cnt,
  output logic [31:0]            perf_busy_cyc
`endif
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid only in DONE, and out_state is
  // held stable there until out_ready.

  localparam int W  = WIDTH * 31;
  localparam int RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [RW-1:0] LAST_ROUND = RW'(NUM_ROUNDS - 1);
  localparam logic [CW-1:0] LAST_WAIT  = CW'(LAT - 1);

  m31_frd_state_e state, state_next;

  logic [W-1:0]  work;
  logic [RW-1:0] round;
  logic [CW-1:0] wcnt;

  logic wait_last;
  assign wait_last = (wcnt == LAST_WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid) state_next = S_FETCH;
      S_FETCH: state_next = S_LOAD;
      S_LOAD:  state_next = S_WAIT;
      S_WAIT:  if (wait_last) state_next = (round == LAST_ROUND) ? S_DONE : S_FETCH;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // rc_addr is registered so it is already valid during FETCH; the RC memory
  // returns data in LOAD, which is registered into fr_const_o on leaving LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work       <= '0;
      round      <= '0;
      wcnt       <= '0;
      rc_addr    <= '0;
      fr_state_o <= '0;
      fr_const_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            work    <= in_state;
            round   <= '0;
            rc_addr <= RC_AW'(RC_BASE);
          end
        end
        S_LOAD: begin
          fr_const_o <= rc_data;
          fr_state_o <= work;
          wcnt       <= '0;
        end
        S_WAIT: begin
          wcnt <= wcnt + CW'(1);
          if (wait_last) begin
            work <= fr_state_i;
            if (round != LAST_ROUND) begin
              round   <= round + RW'(1);
              rc_addr <= RC_AW'(RC_BASE) + RC_AW'(round) + RC_AW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign out_state = work;
  assign fsm_state = state;

`ifdef M31_FULL_ROUND_DRIVER_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cnt      <= '0;
      perf_busy_cyc <= '0;
    end else begin
      if (out_valid && out_ready && (perf_cnt != 32'hFFFF_FFFF))
        perf_cnt <= perf_cnt + 32'd1;
      if (busy && (perf_busy_cyc != 32'hFFFF_FFFF))
        perf_busy_cyc <= perf_busy_cyc + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_m31_full_round_driver.sv
// Directed bench: two driver instances (1 and 4 rounds) sharing an RC memory,
// each feeding a behavioural Poseidon2 M31 full-round pipeline.
module tb_m31_full_round_driver;
  import m31_pkg::*;

  localparam int WIDTH = 16;
  localparam int LAT   = 13;
  localparam int RC_AW = 6;
  localparam int W     = WIDTH * 31;
  localparam logic [63:0] P = {33'd0, M31_P};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic             in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
  logic [W-1:0]     in_state_a, out_state_a, rc_data_a, fso_a, fco_a, fsi_a;
  logic [RC_AW-1:0] rc_addr_a;
  logic [2:0]       fsm_a;
  logic             in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
  logic [W-1:0]     in_state_b, out_state_b, rc_data_b, fso_b, fco_b, fsi_b;
  logic [RC_AW-1:0] rc_addr_b;
  logic [2:0]       fsm_b;
`ifdef M31_FULL_ROUND_DRIVER_PERF_EN
  logic [31:0] perf_cnt_a, perf_busy_a, perf_cnt_b, perf_busy_b;
`endif

  logic [W-1:0] rc_mem [64];
  logic [W-1:0] pipe_a [LAT-1];
  logic [W-1:0] pipe_b [LAT-1];

  m31_full_round_driver #(.WIDTH(WIDTH), .NUM_ROUNDS(1), .LAT(LAT), .RC_AW(RC_AW), .RC_BASE(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a), .in_state(in_state_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_state(out_state_a), .rc_addr(rc_addr_a),
    .rc_data(rc_data_a), .fr_state_o(fso_a), .fr_const_o(fco_a), .fr_state_i(fsi_a), .busy(busy_a),
    .fsm_state(fsm_a)
`ifdef M31_FULL_ROUND_DRIVER_PERF_EN
    , .perf_cnt(perf_cnt_a), .perf_busy_cyc(perf_busy_a)
`endif
  );

  m31_full_round_driver #(.WIDTH(WIDTH), .NUM_ROUNDS(4), .LAT(LAT), .RC_AW(RC_AW), .RC_BASE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b), .in_state(in_state_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_state(out_state_b), .rc_addr(rc_addr_b),
    .rc_data(rc_data_b), .fr_state_o(fso_b), .fr_const_o(fco_b), .fr_state_i(fsi_b), .busy(busy_b),
    .fsm_state(fsm_b)
`ifdef M31_FULL_ROUND_DRIVER_PERF_EN
    , .perf_cnt(perf_cnt_b), .perf_busy_cyc(perf_busy_b)
`endif
  );

  function automatic logic [63:0] mulm(input logic [63:0] x, input logic [63:0] y);
    return (x * y) % P;
  endfunction

  // Poseidon2 external round: add constants, x^5, then circ(2*M4, M4, M4, M4).
  function automatic logic [W-1:0] full_round(input logic [W-1:0] s, input logic [W-1:0] c);
    logic [63:0] x [16];
    logic [63:0] t [16];
    logic [63:0] sums [4];
    logic [63:0] x2, x4, a0, a1, a2, a3;
    logic [W-1:0] r;
    for (int i = 0; i < 16; i++) begin
      x[i] = ({33'd0, s[i*31 +: 31]} + {33'd0, c[i*31 +: 31]}) % P;
      x2 = mulm(x[i], x[i]);
      x4 = mulm(x2, x2);
      x[i] = mulm(x4, x[i]);
    end
    for (int b = 0; b < 4; b++) begin
      a0 = x[4*b]; a1 = x[4*b+1]; a2 = x[4*b+2]; a3 = x[4*b+3];
      t[4*b]   = (2*a0 + 3*a1 + a2 + a3) % P;
      t[4*b+1] = (a0 + 2*a1 + 3*a2 + a3) % P;
      t[4*b+2] = (a0 + a1 + 2*a2 + 3*a3) % P;
      t[4*b+3] = (3*a0 + a1 + a2 + 2*a3) % P;
    end
    for (int k = 0; k < 4; k++) sums[k] = 64'd0;
    for (int i = 0; i < 16; i++) sums[i%4] = sums[i%4] + t[i];
    for (int i = 0; i < 16; i++) r[i*31 +: 31] = 31'((t[i] + sums[i%4]) % P);
    return r;
  endfunction

  function automatic logic [30:0] wd(input logic [W-1:0] v, input int i);
    return v[i*31 +: 31];
  endfunction

  // Datapath model: result of the inputs present in a cycle reaches fr_state_i
  // LAT-1 edges later, so it is readable during the last WAIT cycle.
  always @(posedge clk) begin
    rc_data_a <= rc_mem[rc_addr_a];
    rc_data_b <= rc_mem[rc_addr_b];
    pipe_a[0] <= full_round(fso_a, fco_a);
    pipe_b[0] <= full_round(fso_b, fco_b);
    for (int k = 1; k < LAT-1; k++) begin
      pipe_a[k] <= pipe_a[k-1];
      pipe_b[k] <= pipe_b[k-1];
    end
  end
  assign fsi_a = pipe_a[LAT-2];
  assign fsi_b = pipe_b[LAT-2];

  logic [W-1:0] vec1_state, vec1_rc;

  task automatic send_a(input logic [W-1:0] s);
    int n = 0;
    in_state_a = s;
    in_valid_a = 1'b1;
    while (!in_ready_a && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid_a = 1'b0;
  endtask

  task automatic send_b(input logic [W-1:0] s);
    int n = 0;
    in_state_b = s;
    in_valid_b = 1'b1;
    while (!in_ready_b && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid_b = 1'b0;
  endtask

  task automatic wait_out_a(output int cyc);
    cyc = 0;
    while (!out_valid_a && cyc < 200) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic wait_out_b(output int cyc);
    cyc = 0;
    while (!out_valid_b && cyc < 200) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic test_reset;
    checks++;
    if ({in_ready_a, out_valid_a, busy_a, fsm_a} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctl_a got=%b want=100000", {in_ready_a, out_valid_a, busy_a, fsm_a});
    end
    checks++;
    if ({in_ready_b, out_valid_b, busy_b, fsm_b} !== 6'b100000) begin
      errors++; $display("FAIL reset_ctl_b got=%b want=100000", {in_ready_b, out_valid_b, busy_b, fsm_b});
    end
    checks++;
    if ({rc_addr_a, out_state_a, fso_a, fco_a} !== '0 || {rc_addr_b, out_state_b, fso_b, fco_b} !== '0) begin
      errors++; $display("FAIL reset_data got rc_addr_a=%0d rc_addr_b=%0d want all zero", rc_addr_a, rc_addr_b);
    end
  endtask

  task automatic test_single_round;
    int cyc;
    send_a(vec1_state);
    wait_out_a(cyc);
    checks++;
    if (cyc !== 15) begin errors++; $display("FAIL one_round_latency got=%0d want=15", cyc); end
    checks++;
    if (wd(out_state_a, 0) !== 31'd2089068860 || wd(out_state_a, 1) !== 31'd1384985267) begin
      errors++; $display("FAIL one_round_w0_w1 got=%0d,%0d want=2089068860,1384985267", wd(out_state_a, 0), wd(out_state_a, 1));
    end
    checks++;
    if (wd(out_state_a, 7) !== 31'd968278844 || wd(out_state_a, 15) !== 31'd464369286) begin
      errors++; $display("FAIL one_round_w7_w15 got=%0d,%0d want=968278844,464369286", wd(out_state_a, 7), wd(out_state_a, 15));
    end
    checks++;
    if (out_state_a !== full_round(vec1_state, vec1_rc)) begin
      errors++; $display("FAIL one_round_vector got=%h want=%h", out_state_a, full_round(vec1_state, vec1_rc));
    end
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    out_ready_a = 1'b0;
    checks++;
    if (out_valid_a !== 1'b0 || in_ready_a !== 1'b1) begin
      errors++; $display("FAIL one_round_release got out_valid=%b in_ready=%b want 0,1", out_valid_a, in_ready_a);
    end
  endtask

  task automatic test_zero_state;
    int cyc;
    int bad = 0;
    for (int i = 0; i < 16; i++) rc_mem[0][i*31 +: 31] = 31'd1000;
    send_a('0);
    wait_out_a(cyc);
    for (int i = 0; i < 16; i++) if (wd(out_state_a, i) !== 31'd136065185) bad++;
    checks++;
    if (cyc !== 15 || bad != 0) begin
      errors++; $display("FAIL zero_state got cyc=%0d bad_words=%0d w0=%0d want cyc=15 w=136065185", cyc, bad, wd(out_state_a, 0));
    end
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    out_ready_a = 1'b0;
    rc_mem[0] = vec1_rc;
  endtask

  task automatic test_four_rounds;
    logic [W-1:0] s, exp;
    int cyc = 0;
    int bad_addr = 0;
    for (int i = 0; i < 16; i++) s[i*31 +: 31] = 31'(i * 123457 + 9);
    exp = s;
    for (int r = 0; r < 4; r++) exp = full_round(exp, rc_mem[r]);
    send_b(s);
    while (!out_valid_b && cyc < 200) begin
      if (cyc % 15 == 0 && rc_addr_b !== RC_AW'(cyc / 15)) begin
        bad_addr++;
        $display("FAIL rc_addr_seq cycle=%0d got=%0d want=%0d", cyc, rc_addr_b, cyc / 15);
      end
      @(posedge clk); #1; cyc++;
    end
    checks++;
    if (bad_addr != 0) errors++;
    checks++;
    if (cyc !== 60) begin errors++; $display("FAIL four_round_latency got=%0d want=60", cyc); end
    checks++;
    if (out_state_b !== exp) begin errors++; $display("FAIL four_round_vector got=%h want=%h", out_state_b, exp); end
    out_ready_b = 1'b1;
    @(posedge clk); #1;
    out_ready_b = 1'b0;
  endtask

  task automatic test_backpressure;
    logic [W-1:0] s, exp;
    int cyc;
    int bad = 0;
    for (int i = 0; i < 16; i++) s[i*31 +: 31] = 31'(31'h7FFF_FF00 + i);
    exp = s;
    for (int r = 0; r < 4; r++) exp = full_round(exp, rc_mem[r]);
    send_b(s);
    wait_out_b(cyc);
    for (int k = 0; k < 20; k++) begin
      if (out_valid_b !== 1'b1 || in_ready_b !== 1'b0 || out_state_b !== exp) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (cyc !== 60 || bad != 0) begin
      errors++; $display("FAIL backpressure_hold got cyc=%0d bad_cycles=%0d want 60,0", cyc, bad);
    end
    out_ready_b = 1'b1;
    @(posedge clk); #1;
    out_ready_b = 1'b0;
    checks++;
    if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1) begin
      errors++; $display("FAIL backpressure_release got out_valid=%b in_ready=%b want 0,1", out_valid_b, in_ready_b);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] sa, sb, ea, eb;
    int cyc;
    for (int i = 0; i < 16; i++) begin
      sa[i*31 +: 31] = 31'(i * 7 + 1);
      sb[i*31 +: 31] = 31'(1000000 - i * 31);
    end
    ea = sa; eb = sb;
    for (int r = 0; r < 4; r++) begin
      ea = full_round(ea, rc_mem[r]);
      eb = full_round(eb, rc_mem[r]);
    end
    out_ready_b = 1'b1;
    in_state_b = sa;
    in_valid_b = 1'b1;
    @(posedge clk); #1;
    in_state_b = sb;
    wait_out_b(cyc);
    checks++;
    if (cyc !== 60 || out_state_b !== ea) begin
      errors++; $display("FAIL b2b_first got cyc=%0d w0=%0d want cyc=60 w0=%0d", cyc, wd(out_state_b, 0), wd(ea, 0));
    end
    @(posedge clk); #1;
    checks++;
    if (out_valid_b !== 1'b0 || in_ready_b !== 1'b1) begin
      errors++; $display("FAIL b2b_gap got out_valid=%b in_ready=%b want 0,1", out_valid_b, in_ready_b);
    end
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    checks++;
    if (in_ready_b !== 1'b0 || busy_b !== 1'b1) begin
      errors++; $display("FAIL b2b_second_accept got in_ready=%b busy=%b want 0,1", in_ready_b, busy_b);
    end
    wait_out_b(cyc);
    checks++;
    if (cyc !== 60 || out_state_b !== eb) begin
      errors++; $display("FAIL b2b_second got cyc=%0d w0=%0d want cyc=60 w0=%0d", cyc, wd(out_state_b, 0), wd(eb, 0));
    end
    @(posedge clk); #1;
    out_ready_b = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [W-1:0] exp;
    int cyc;
    exp = vec1_state;
    for (int r = 0; r < 4; r++) exp = full_round(exp, rc_mem[r]);
    send_b(vec1_state);
    repeat (36) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready_b, out_valid_b, busy_b, fsm_b} !== 6'b100000 || {rc_addr_b, out_state_b, fso_b, fco_b} !== '0) begin
      errors++; $display("FAIL mid_reset got in_ready=%b busy=%b fsm=%0d rc_addr=%0d want 1,0,0,0", in_ready_b, busy_b, fsm_b, rc_addr_b);
    end
`ifdef M31_FULL_ROUND_DRIVER_PERF_EN
    checks++;
    if (perf_cnt_b !== 32'd0 || perf_busy_b !== 32'd0) begin
      errors++; $display("FAIL perf_reset got cnt=%0d busy=%0d want 0,0", perf_cnt_b, perf_busy_b);
    end
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send_a(vec1_state);
    wait_out_a(cyc);
    checks++;
    if (cyc !== 15 || wd(out_state_a, 0) !== 31'd2089068860 || wd(out_state_a, 15) !== 31'd464369286) begin
      errors++; $display("FAIL post_reset_one_round got cyc=%0d w0=%0d w15=%0d want 15,2089068860,464369286", cyc, wd(out_state_a, 0), wd(out_state_a, 15));
    end
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    out_ready_a = 1'b0;
    send_b(vec1_state);
    wait_out_b(cyc);
    checks++;
    if (cyc !== 60 || out_state_b !== exp) begin
      errors++; $display("FAIL post_reset_four_round got cyc=%0d w0=%0d want 60,%0d", cyc, wd(out_state_b, 0), wd(exp, 0));
    end
    out_ready_b = 1'b1;
    @(posedge clk); #1;
    out_ready_b = 1'b0;
`ifdef M31_FULL_ROUND_DRIVER_PERF_EN
    checks++;
    if (perf_cnt_b !== 32'd1 || perf_busy_b !== 32'd61) begin
      errors++; $display("FAIL perf_count got cnt=%0d busy=%0d want 1,61", perf_cnt_b, perf_busy_b);
    end
`endif
  endtask

  initial begin
    in_valid_a = 1'b0; out_ready_a = 1'b0; in_state_a = '0;
    in_valid_b = 1'b0; out_ready_b = 1'b0; in_state_b = '0;
    for (int i = 0; i < 16; i++) begin
      vec1_state[i*31 +: 31] = 31'(i + 1);
      vec1_rc[i*31 +: 31]    = 31'(100 * (i + 1));
    end
    for (int r = 0; r < 64; r++)
      for (int i = 0; i < 16; i++) rc_mem[r][i*31 +: 31] = 31'(r * 1000003 + i * 7919 + 5);
    rc_mem[0] = vec1_rc;
    repeat (2) @(posedge clk);
    #1;
    test_reset;
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_single_round;
    test_zero_state;
    test_four_rounds;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
